// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts instructions, feeds a combinational ALU from a register file, retires results and flags
// Ports: clk/rst; instr_valid/instr_ready handshake with instr_opcode/rd/rs/imm/use_imm;
//        alu_opcode/alu_a/alu_b registered to the ALU, alu_out/alu_z/n/c/o back from it;
//        flags {Z,N,C,O}, done/illegal/div0 retire pulses, dbg_addr/dbg_data register peek.
module alu_sequencer #(
  parameter int DW = 16,
  parameter int NREG = 8,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [5:0]    instr_opcode,
  input  logic [RW-1:0] instr_rd,
  input  logic [RW-1:0] instr_rs,
  input  logic [DW-1:0] instr_imm,
  input  logic          instr_use_imm,
  output logic [5:0]    alu_opcode,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_c,
  input  logic          alu_o,
  output logic [3:0]    flags,
  output logic          done,
  output logic          illegal,
  output logic          div0,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, TRAP} state_t;
  state_t state;
  logic [DW-1:0] rf [NREG];
  logic [RW-1:0] rd_q;
  logic wb_q, ill_q;
  logic [DW-1:0] b_sel;
  logic bad, dz, unary, accept;
  assign instr_ready = state == IDLE;
  assign accept = instr_valid && instr_ready;
  assign dbg_data = rf[dbg_addr];
  assign b_sel = instr_use_imm ? instr_imm : rf[instr_rs];
  assign bad = instr_opcode < 6'h0A || instr_opcode > 6'h1B;
  assign dz = (instr_opcode == 6'h12 || instr_opcode == 6'h13) && b_sel == '0;
  assign unary = instr_opcode == 6'h17 || instr_opcode == 6'h1A || instr_opcode == 6'h1B;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      flags <= '0;
      alu_opcode <= '0;
      alu_a <= '0;
      alu_b <= '0;
      done <= 1'b0;
      illegal <= 1'b0;
      div0 <= 1'b0;
      rd_q <= '0;
      wb_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      done <= 1'b0;
      illegal <= 1'b0;
      div0 <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          rd_q <= instr_rd;
          // CMP and TST only update flags
          wb_q <= !(instr_opcode == 6'h18 || instr_opcode == 6'h19);
          ill_q <= bad;
          if (bad || dz) state <= TRAP;
          else begin
            state <= EXEC;
            alu_opcode <= instr_opcode;
            alu_a <= rf[instr_rd];
            alu_b <= unary ? '0 : b_sel;
          end
        end
        EXEC: begin
          state <= IDLE;
          flags <= {alu_z, alu_n, alu_c, alu_o};
          done <= 1'b1;
          if (wb_q) rf[rd_q] <= alu_out;
        end
        TRAP: begin
          state <= IDLE;
          done <= 1'b1;
          illegal <= ill_q;
          div0 <= !ill_q;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a small ALU stub
module tb_alu_sequencer;
  logic clk = 0, rst = 1;
  logic instr_valid = 0, instr_ready, instr_use_imm = 0;
  logic [5:0] instr_opcode = 0, alu_opcode;
  logic [2:0] instr_rd = 0, instr_rs = 0, dbg_addr = 0;
  logic [15:0] instr_imm = 0, alu_a, alu_b, alu_out, dbg_data;
  logic alu_z, alu_n, alu_c, alu_o, done, illegal, div0;
  logic [3:0] flags;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_imm(instr_imm), .instr_use_imm(instr_use_imm), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
    .alu_c(alu_c), .alu_o(alu_o), .flags(flags), .done(done), .illegal(illegal),
    .div0(div0), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  logic [16:0] s;
  always_comb begin
    s = '0;
    alu_o = 1'b0;
    case (alu_opcode)
      6'h0A: begin s = {1'b0, alu_a} + {1'b0, alu_b}; alu_o = alu_a[15] == alu_b[15] && s[15] != alu_a[15]; end
      6'h0B, 6'h18: begin s = {1'b0, alu_a} - {1'b0, alu_b}; alu_o = alu_a[15] != alu_b[15] && s[15] != alu_a[15]; end
      6'h0C, 6'h19: s = {1'b0, alu_a & alu_b};
      6'h10: s = {1'b0, alu_b};
      6'h12: s = alu_b == 0 ? 17'h0 : {1'b0, alu_a / alu_b};
      6'h13: s = alu_b == 0 ? 17'h0 : {1'b0, alu_a % alu_b};
      6'h17: s = {1'b0, ~alu_a};
      6'h1A: s = {1'b0, alu_a} + 17'd1;
      6'h1B: s = {1'b0, alu_a} - 17'd1;
      default: s = '0;
    endcase
    alu_out = s[15:0];
    alu_z = alu_opcode != 6'h10 && alu_out == 0;
    alu_n = alu_opcode != 6'h10 && alu_out[15];
    alu_c = alu_opcode != 6'h10 && s[16];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic reg_is(input logic [2:0] r, input logic [15:0] v);
    dbg_addr = r;
    #1 check($sformatf("rf[%0d]", r), dbg_data, v);
  endtask
  // kind: 0 normal retire, 1 illegal trap, 2 div0 trap; called at a negedge with the DUT idle
  task automatic run(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs,
                     input logic [15:0] imm, input logic ui, input int kind);
    check("ready_idle", instr_ready, 1);
    instr_opcode = op; instr_rd = rd; instr_rs = rs; instr_imm = imm; instr_use_imm = ui;
    instr_valid = 1;
    @(negedge clk);
    instr_valid = 0; instr_imm = 16'hDEAD; instr_rs = ~rs; instr_use_imm = ~ui;
    check("ready_busy", instr_ready, 0);
    check("done_early", done, 0);
    @(negedge clk);
    check("done", done, 1);
    check("illegal", illegal, kind == 1);
    check("div0", div0, kind == 2);
  endtask
  int acc, busy;
  initial begin
    #12;
    check("rst_ready", instr_ready, 1);
    check("rst_flags", flags, 0);
    check("rst_done", done, 0);
    check("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
    reg_is(0, 0);
    @(negedge clk) rst = 0;
    @(negedge clk);
    run(6'h10, 1, 0, 16'h7FFF, 1, 0);
    reg_is(1, 16'h7FFF);
    check("mov_flags", flags, 4'b0000);
    run(6'h0A, 1, 0, 16'h0001, 1, 0);
    reg_is(1, 16'h8000);
    check("add_flags", flags, 4'b0101);
    @(negedge clk);
    check("done_pulse", done, 0);
    run(6'h10, 2, 0, 16'h0005, 1, 0);
    run(6'h18, 2, 0, 16'h0005, 1, 0);
    check("cmp_flags", flags, 4'b1000);
    reg_is(2, 5);
    run(6'h19, 2, 0, 16'h0002, 1, 0);
    check("tst_flags", flags, 4'b1000);
    reg_is(2, 5);
    run(6'h10, 3, 0, 16'h0010, 1, 0);
    run(6'h18, 2, 0, 16'h0005, 1, 0);
    run(6'h12, 3, 0, 16'h0000, 1, 2);
    reg_is(3, 16'h0010);
    check("div0_flags", flags, 4'b1000);
    check("div0_alu", {alu_opcode, alu_a, alu_b}, {6'h18, 16'h5, 16'h5});
    run(6'h12, 3, 2, 16'h0000, 0, 0);
    reg_is(3, 3);
    check("div_flags", flags, 4'b0000);
    run(6'h05, 3, 0, 16'h0007, 1, 1);
    run(6'h3F, 3, 0, 16'h0007, 1, 1);
    reg_is(3, 3);
    check("ill_alu", {alu_opcode, alu_a, alu_b}, {6'h12, 16'h10, 16'h5});
    run(6'h13, 1, 1, 16'h0000, 0, 0);
    reg_is(1, 0);
    instr_opcode = 6'h1A; instr_rd = 2; instr_imm = 16'hFFFF; instr_use_imm = 1;
    instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    check("inc_b_zero", alu_b, 0);
    @(negedge clk);
    reg_is(2, 6);
    acc = 0; busy = 0;
    instr_opcode = 6'h1A; instr_rd = 5; instr_use_imm = 1; instr_valid = 1;
    for (int i = 0; i < 6; i++) begin
      if (instr_ready) acc++; else busy++;
      @(posedge clk);
      #1;
    end
    instr_valid = 0;
    check("hold_accepts", acc, 3);
    check("hold_busy", busy, 3);
    @(negedge clk);
    reg_is(5, 3);
    run(6'h18, 2, 0, 16'h0006, 1, 0);
    check("pre_rst_flags", flags, 4'b1000);
    instr_opcode = 6'h0A; instr_rd = 4; instr_imm = 1; instr_use_imm = 1; instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    rst = 1;
    @(negedge clk);
    check("rst_no_done", done, 0);
    check("rst_flags2", flags, 0);
    reg_is(4, 0);
    reg_is(2, 0);
    @(negedge clk) rst = 0;
    check("rst_ready2", instr_ready, 1);
    @(negedge clk);
    check("rst_no_done2", done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
